// File: rtl/controlador_turnos.sv
// Turn controller: takes the initializer handshake, alternates the active player
// on each committed move, forfeits expired turns and freezes when the game ends.
module controlador_turnos #(
    parameter int unsigned CICLOS_POR_SEG = 50_000_000,
    parameter int unsigned SEGUNDOS_TURNO = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       listo,
    input  logic       jugador_inicial,
    input  logic       jugada_valida,
    input  logic       juego_terminado,
    output logic       jugador_actual,
    output logic       turno_activo,
    output logic [3:0] tiempo_restante,
    output logic       timeout,
    output logic       cambio_turno,
    output logic       fin
);

    localparam int unsigned PW = (CICLOS_POR_SEG > 1) ? $clog2(CICLOS_POR_SEG) : 1;
    localparam logic [PW-1:0] PRESC_MAX  = PW'(CICLOS_POR_SEG - 1);
    localparam logic [3:0]    TIEMPO_INI = 4'(SEGUNDOS_TURNO);

    typedef enum logic [1:0] {StEspera, StTurno, StCambio, StFin} estado_e;

    estado_e       state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          jugador_q, jugador_d;
    logic          activo_q, activo_d;
    logic [3:0]    tiempo_q, tiempo_d;
    logic          timeout_q, timeout_d;
    logic          cambio_q, cambio_d;
    logic          fin_q, fin_d;

    logic wrap;
    logic expira;

    assign wrap   = (presc_q == PRESC_MAX);
    assign expira = wrap && (tiempo_q == 4'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StEspera;
            presc_q   <= '0;
            jugador_q <= 1'b0;
            activo_q  <= 1'b0;
            tiempo_q  <= 4'd0;
            timeout_q <= 1'b0;
            cambio_q  <= 1'b0;
            fin_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            jugador_q <= jugador_d;
            activo_q  <= activo_d;
            tiempo_q  <= tiempo_d;
            timeout_q <= timeout_d;
            cambio_q  <= cambio_d;
            fin_q     <= fin_d;
        end
    end

    // Priority in TURNO: game end, then move, then expiry.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StEspera: begin
                if (listo) state_d = StTurno;
            end
            StTurno: begin
                if (juego_terminado)    state_d = StFin;
                else if (jugada_valida) state_d = StCambio;
                else if (expira)        state_d = StCambio;
            end
            StCambio: begin
                if (juego_terminado) state_d = StFin;
                else                 state_d = StTurno;
            end
            StFin:   state_d = StFin;
            default: state_d = StEspera;
        endcase
    end

    always_comb begin
        presc_d   = presc_q;
        jugador_d = jugador_q;
        activo_d  = activo_q;
        tiempo_d  = tiempo_q;
        timeout_d = 1'b0;
        cambio_d  = 1'b0;
        fin_d     = fin_q;
        case (state_q)
            StEspera: begin
                if (listo) begin
                    jugador_d = jugador_inicial;
                    tiempo_d  = TIEMPO_INI;
                    presc_d   = '0;
                    activo_d  = 1'b1;
                end
            end
            StTurno: begin
                if (juego_terminado) begin
                    fin_d    = 1'b1;
                    activo_d = 1'b0;
                end else if (jugada_valida) begin
                    activo_d = 1'b0;
                end else begin
                    presc_d = wrap ? '0 : presc_q + PW'(1);
                    if (wrap && (tiempo_q != 4'd0)) tiempo_d = tiempo_q - 4'd1;
                    if (expira) begin
                        timeout_d = 1'b1;
                        activo_d  = 1'b0;
                    end
                end
            end
            StCambio: begin
                if (juego_terminado) begin
                    fin_d    = 1'b1;
                    activo_d = 1'b0;
                end else begin
                    jugador_d = ~jugador_q;
                    tiempo_d  = TIEMPO_INI;
                    presc_d   = '0;
                    cambio_d  = 1'b1;
                    activo_d  = 1'b1;
                end
            end
            StFin: begin
                fin_d    = 1'b1;
                activo_d = 1'b0;
            end
            default: ;
        endcase
    end

    assign jugador_actual  = jugador_q;
    assign turno_activo    = activo_q;
    assign tiempo_restante = tiempo_q;
    assign timeout         = timeout_q;
    assign cambio_turno    = cambio_q;
    assign fin             = fin_q;

endmodule

// File: tb/tb_controlador_turnos.sv
// Bench for controlador_turnos: directed scenarios plus random stimulus against
// a cycle-count based model of turns.
module tb_controlador_turnos;

    localparam int C = 4;
    localparam int S = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       listo = 1'b0;
    logic       jugador_inicial = 1'b0;
    logic       jugada_valida = 1'b0;
    logic       juego_terminado = 1'b0;
    logic       jugador_actual;
    logic       turno_activo;
    logic [3:0] tiempo_restante;
    logic       timeout;
    logic       cambio_turno;
    logic       fin;

    int total = 0;
    int bad = 0;

    // Model: turn progress expressed as cycles elapsed since the turn started.
    bit   m_jugando, m_cambiando, m_fin, m_jugador, m_activo, m_timeout, m_cambio;
    int   m_ciclos;
    int   m_tiempo;

    wire [8:0] salidas = {jugador_actual, turno_activo, tiempo_restante, timeout,
                          cambio_turno, fin};
    logic [8:0] esperado;

    controlador_turnos #(
        .CICLOS_POR_SEG(C),
        .SEGUNDOS_TURNO(S)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .listo          (listo),
        .jugador_inicial(jugador_inicial),
        .jugada_valida  (jugada_valida),
        .juego_terminado(juego_terminado),
        .jugador_actual (jugador_actual),
        .turno_activo   (turno_activo),
        .tiempo_restante(tiempo_restante),
        .timeout        (timeout),
        .cambio_turno   (cambio_turno),
        .fin            (fin)
    );

    always #5 clk = ~clk;

    task automatic model_step();
        if (reset) begin
            m_jugando = 0; m_cambiando = 0; m_fin = 0; m_jugador = 0; m_activo = 0;
            m_timeout = 0; m_cambio = 0; m_ciclos = 0; m_tiempo = 0;
            return;
        end
        m_timeout = 0;
        m_cambio  = 0;
        if (m_fin) begin
            m_activo = 0;
        end else if (m_cambiando) begin
            m_cambiando = 0;
            if (juego_terminado) begin
                m_fin = 1; m_activo = 0;
            end else begin
                m_jugador = !m_jugador; m_ciclos = 0; m_tiempo = S;
                m_cambio = 1; m_activo = 1; m_jugando = 1;
            end
        end else if (m_jugando) begin
            if (juego_terminado) begin
                m_fin = 1; m_activo = 0; m_jugando = 0;
            end else if (jugada_valida) begin
                m_activo = 0; m_cambiando = 1; m_jugando = 0;
            end else begin
                m_ciclos++;
                if (m_ciclos == S * C) begin
                    m_tiempo = 0; m_timeout = 1; m_activo = 0;
                    m_cambiando = 1; m_jugando = 0;
                end else begin
                    m_tiempo = S - m_ciclos / C;
                end
            end
        end else if (listo) begin
            m_jugador = jugador_inicial; m_tiempo = S; m_ciclos = 0;
            m_activo = 1; m_jugando = 1;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        total++;
        if (salidas !== 9'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%b want=%b", salidas, 9'd0);
        end
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            jugada_valida = i[0];
            tick();
            total++;
            if (salidas !== 9'd0) begin
                bad++;
                $display("FAIL espera_ignores_move got=%b want=%b", salidas, 9'd0);
            end
        end
        jugada_valida = 1'b0;
    endtask

    task automatic test_inicio();
        jugador_inicial = 1'b1;
        listo = 1'b1;
        tick();
        listo = 1'b0;
        jugador_inicial = 1'b0;
        esperado = {1'b1, 1'b1, 4'd3, 3'b000};
        total++;
        if (salidas !== esperado) begin
            bad++;
            $display("FAIL inicio got=%b want=%b", salidas, esperado);
        end
        for (int i = 0; i < 4; i++) tick();
        total++;
        if (tiempo_restante !== 4'd2) begin
            bad++;
            $display("FAIL first_second got=%0d want=2", tiempo_restante);
        end
    endtask

    task automatic test_jugada();
        jugada_valida = 1'b1;
        tick();
        jugada_valida = 1'b0;
        esperado = {1'b1, 1'b0, 4'd2, 3'b000};
        total++;
        if (salidas !== esperado) begin
            bad++;
            $display("FAIL jugada_cambio got=%b want=%b", salidas, esperado);
        end
        tick();
        esperado = {1'b0, 1'b1, 4'd3, 3'b010};
        total++;
        if (salidas !== esperado) begin
            bad++;
            $display("FAIL jugada_switch got=%b want=%b", salidas, esperado);
        end
    endtask

    task automatic test_timeout();
        for (int i = 1; i <= S * C - 1; i++) begin
            tick();
            esperado = {1'b0, 1'b1, 4'(S - i / C), 3'b000};
            total++;
            if (salidas !== esperado) begin
                bad++;
                $display("FAIL countdown_%0d got=%b want=%b", i, salidas, esperado);
            end
        end
        tick();
        esperado = {1'b0, 1'b0, 4'd0, 3'b100};
        total++;
        if (salidas !== esperado) begin
            bad++;
            $display("FAIL timeout_pulse got=%b want=%b", salidas, esperado);
        end
        tick();
        esperado = {1'b1, 1'b1, 4'd3, 3'b010};
        total++;
        if (salidas !== esperado) begin
            bad++;
            $display("FAIL timeout_switch got=%b want=%b", salidas, esperado);
        end
    endtask

    task automatic test_jugada_en_expiracion();
        for (int i = 0; i < S * C - 1; i++) tick();
        jugada_valida = 1'b1;
        tick();
        jugada_valida = 1'b0;
        esperado = {1'b1, 1'b0, 4'd1, 3'b000};
        total++;
        if (salidas !== esperado) begin
            bad++;
            $display("FAIL move_on_expiry got=%b want=%b", salidas, esperado);
        end
        tick();
        esperado = {1'b0, 1'b1, 4'd3, 3'b010};
        total++;
        if (salidas !== esperado) begin
            bad++;
            $display("FAIL move_on_expiry_switch got=%b want=%b", salidas, esperado);
        end
    endtask

    task automatic test_fin();
        for (int i = 0; i < 5; i++) tick();
        juego_terminado = 1'b1;
        jugada_valida = 1'b1;
        tick();
        juego_terminado = 1'b0;
        esperado = {1'b0, 1'b0, 4'd2, 3'b001};
        total++;
        if (salidas !== esperado) begin
            bad++;
            $display("FAIL fin_entry got=%b want=%b", salidas, esperado);
        end
        listo = 1'b1;
        jugador_inicial = 1'b1;
        for (int i = 0; i < 6; i++) begin
            jugada_valida = i[0];
            tick();
            total++;
            if (salidas !== esperado) begin
                bad++;
                $display("FAIL fin_frozen got=%b want=%b", salidas, esperado);
            end
        end
        listo = 1'b0;
        jugada_valida = 1'b0;
        jugador_inicial = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++;
        if (salidas !== 9'd0) begin
            bad++;
            $display("FAIL fin_reset got=%b want=%b", salidas, 9'd0);
        end
    endtask

    task automatic test_reset_mitad();
        jugador_inicial = 1'b1;
        listo = 1'b1;
        tick();
        listo = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        total++;
        if (tiempo_restante !== 4'd2) begin
            bad++;
            $display("FAIL mid_turn_time got=%0d want=2", tiempo_restante);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++;
        if (salidas !== 9'd0) begin
            bad++;
            $display("FAIL mid_turn_reset got=%b want=%b", salidas, 9'd0);
        end
        jugador_inicial = 1'b0;
        listo = 1'b1;
        tick();
        listo = 1'b0;
        esperado = {1'b0, 1'b1, 4'd3, 3'b000};
        total++;
        if (salidas !== esperado) begin
            bad++;
            $display("FAIL restart got=%b want=%b", salidas, esperado);
        end
    endtask

    task automatic test_aleatorio();
        for (int i = 0; i < 3000; i++) begin
            reset           = ($urandom_range(0, 399) == 0);
            listo           = ($urandom_range(0, 7) == 0);
            jugador_inicial = $urandom_range(0, 1) == 1;
            jugada_valida   = ($urandom_range(0, 9) == 0);
            juego_terminado = ($urandom_range(0, 199) == 0);
            tick();
            esperado = {m_jugador, m_activo, 4'(m_tiempo), m_timeout, m_cambio, m_fin};
            total++;
            if (salidas !== esperado) begin
                bad++;
                $display("FAIL random_cycle_%0d got=%b want=%b", i, salidas, esperado);
            end
            total++;
            if ((timeout && cambio_turno) !== 1'b0) begin
                bad++;
                $display("FAIL pulse_overlap_%0d got=1 want=0", i);
            end
        end
        reset = 1'b0;
        listo = 1'b0;
        jugada_valida = 1'b0;
        juego_terminado = 1'b0;
    endtask

    initial begin
        test_reset();
        test_inicio();
        test_jugada();
        test_timeout();
        test_jugada_en_expiracion();
        test_fin();
        test_reset_mitad();
        test_aleatorio();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
